// File: rtl/sv32_ptw.sv
// Sv32 hardware page-table walker: fetches up to two PTEs on a TLB miss and
// emits either a one-cycle TLB refill or a one-cycle page fault.
module sv32_ptw #(
    parameter int ASID_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [21:0]           satp_ppn_i,
    input  logic [ASID_WIDTH-1:0] asid_i,
    input  logic                  walk_req_i,
    input  logic [31:0]           walk_vaddr_i,
    input  logic                  walk_is_store_i,
    output logic                  busy_o,
    output logic                  mem_req_o,
    output logic [33:0]           mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic                  update_valid_o,
    output logic [19:0]           update_vpn_o,
    output logic [ASID_WIDTH-1:0] update_asid_o,
    output logic                  update_is_4M_o,
    output logic [31:0]           update_content_o,
    output logic                  fault_o,
    output logic [31:0]           fault_vaddr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_DONE,
        S_FAULT,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic [31:0]           r_vaddr;
    logic [ASID_WIDTH-1:0] r_asid;
    logic                  r_store;
    logic                  r_lvl;
    logic                  r_mem_req;
    logic [33:0]           r_mem_addr;
    logic                  r_upd_valid;
    logic                  r_is_4M;
    logic [31:0]           r_pte;
    logic                  r_fault;

    logic        w_v;
    logic        w_r;
    logic        w_w;
    logic        w_x;
    logic        w_a;
    logic        w_d;
    logic        w_leaf;
    logic        w_fault;
    logic [21:0] w_ppn;
    logic [9:0]  w_ppn0;
    logic [33:0] w_root_addr;
    logic [33:0] w_next_addr;

    assign w_v    = mem_rdata_i[0];
    assign w_r    = mem_rdata_i[1];
    assign w_w    = mem_rdata_i[2];
    assign w_x    = mem_rdata_i[3];
    assign w_a    = mem_rdata_i[6];
    assign w_d    = mem_rdata_i[7];
    assign w_ppn  = mem_rdata_i[31:10];
    assign w_ppn0 = mem_rdata_i[19:10];
    assign w_leaf = w_r | w_x;

    // A pointer is only legal at level 1; leaves need A, D on stores, and
    // a megapage must be aligned (ppn0 == 0).
    assign w_fault = ~w_v | (w_w & ~w_r)
                   | (w_leaf ? (~w_a | (r_store & ~w_d)
                                | (r_lvl & (w_ppn0 != 10'h0)))
                             : ~r_lvl);

    assign w_root_addr = {satp_ppn_i, 12'h000}
                       + {22'h0, walk_vaddr_i[31:22], 2'b00};
    assign w_next_addr = {w_ppn, 12'h000}
                       + {22'h0, r_vaddr[21:12], 2'b00};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_vaddr     <= '0;
            r_asid      <= '0;
            r_store     <= 1'b0;
            r_lvl       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_upd_valid <= 1'b0;
            r_is_4M     <= 1'b0;
            r_pte       <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_upd_valid <= 1'b0;
            r_fault     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (walk_req_i && !flush_i) begin
                        r_vaddr    <= walk_vaddr_i;
                        r_asid     <= asid_i;
                        r_store    <= walk_is_store_i;
                        r_lvl      <= 1'b1;
                        r_mem_addr <= w_root_addr;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= mem_gnt_i ? S_DRAIN : S_IDLE;
                    end else if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT_R;
                    end
                end
                S_WAIT_R: begin
                    if (flush_i) begin
                        // Response landing this cycle is already consumed.
                        r_state <= mem_rvalid_i ? S_IDLE : S_DRAIN;
                    end else if (mem_rvalid_i) begin
                        if (w_fault) begin
                            r_fault <= 1'b1;
                            r_state <= S_FAULT;
                        end else if (w_leaf) begin
                            r_upd_valid <= 1'b1;
                            r_is_4M     <= r_lvl;
                            r_pte       <= mem_rdata_i;
                            r_state     <= S_DONE;
                        end else begin
                            r_lvl      <= 1'b0;
                            r_mem_addr <= w_next_addr;
                            r_mem_req  <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_DONE: r_state <= S_IDLE;
                S_FAULT: r_state <= S_IDLE;
                S_DRAIN: begin
                    if (mem_rvalid_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Flush in DONE/FAULT must kill the strobe in that same cycle.
    assign update_valid_o   = r_upd_valid & ~flush_i;
    assign fault_o          = r_fault & ~flush_i;
    assign busy_o           = (r_state != S_IDLE);
    assign mem_req_o        = r_mem_req;
    assign mem_addr_o       = r_mem_addr;
    assign update_vpn_o     = r_vaddr[31:12];
    assign update_asid_o    = r_asid;
    assign update_is_4M_o   = r_is_4M;
    assign update_content_o = r_pte;
    assign fault_vaddr_o    = r_vaddr;

    a_rvalid_proto: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rvalid_i |-> (r_state == S_WAIT_R || r_state == S_DRAIN));

endmodule
